// File: rtl/sys_result_writer.sv
// Write-back stage: buffers systolic result rows in a small FIFO and serialises them into word writes.
// Optional ReLU clamp on written words when WB_RELU_EN is defined.
module sys_result_writer #(
  parameter int datawith   = 16,
  parameter int array_size = 2,
  parameter int addr_width = 10,
  parameter int fifo_depth = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           write_start,
  input  logic [addr_width-1:0]          addr_des,
  input  logic [3:0]                     row_count,
  input  logic                           result_valid,
  input  logic [array_size*datawith-1:0] result_in,
  output logic                           result_ready,
  output logic                           mem_we,
  output logic [addr_width-1:0]          mem_addr,
  output logic [datawith-1:0]            mem_wdata,
  input  logic                           mem_ready,
  output logic                           busy,
  output logic                           write_done,
  output logic [1:0]                     dbg_state
);

  localparam int CW = (array_size > 1) ? $clog2(array_size) : 1;
  localparam int PW = $clog2(fifo_depth);
  localparam int RW = array_size * datawith;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [RW-1:0]         fifo_mem [fifo_depth];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic [addr_width-1:0] base;
  logic [3:0]            rows_total;
  logic [4:0]            rows_accepted;
  logic [4:0]            rows_written;
  logic [CW-1:0]         col;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  word_ack;
  logic                  last_col;
  logic                  pop;
  logic [datawith-1:0]   head_word;
  logic [datawith-1:0]   out_word;
  logic [addr_width-1:0] word_addr;

  // Handshakes: a row moves when result_valid && result_ready, a word moves when
  // mem_we && mem_ready; the offering side holds its payload stable until the transfer.
  assign fifo_full    = (count == (PW+1)'(fifo_depth));
  assign fifo_empty   = (count == '0);
  assign result_ready = (state == RUN) && !fifo_full && (rows_accepted < {1'b0, rows_total});
  assign mem_we       = (state == RUN) && !fifo_empty;
  assign push         = result_valid && result_ready;
  assign word_ack     = mem_we && mem_ready;
  assign last_col     = (col == CW'(array_size - 1));
  assign pop          = word_ack && last_col;

  assign head_word = fifo_mem[rd_ptr][col*datawith +: datawith];
`ifdef WB_RELU_EN
  assign out_word  = head_word[datawith-1] ? '0 : head_word;
`else
  assign out_word  = head_word;
`endif

  // Address arithmetic wraps silently at the memory size.
  assign word_addr = base + addr_width'(rows_written * array_size) + addr_width'(col);
  assign mem_addr  = mem_we ? word_addr : '0;
  assign mem_wdata = mem_we ? out_word : '0;

  assign busy       = (state != IDLE);
  assign write_done = (state == DONE);
  assign dbg_state  = state;

  // Row storage carries no reset; the read side is qualified by occupancy.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= result_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      base          <= '0;
      rows_total    <= '0;
      rows_accepted <= '0;
      rows_written  <= '0;
      col           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_start) begin
            base          <= addr_des;
            rows_total    <= row_count;
            rows_accepted <= '0;
            rows_written  <= '0;
            col           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            state         <= (row_count == 4'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (push) begin
            wr_ptr        <= wr_ptr + 1'b1;
            rows_accepted <= rows_accepted + 5'd1;
          end
          if (pop) rd_ptr <= rd_ptr + 1'b1;
          if (push && !pop)      count <= count + 1'b1;
          else if (!push && pop) count <= count - 1'b1;
          if (word_ack) begin
            if (last_col) begin
              col          <= '0;
              rows_written <= rows_written + 5'd1;
              if ((rows_written + 5'd1) == {1'b0, rows_total}) state <= DONE;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_result_writer.sv
// Directed bench for sys_result_writer: scoreboard queues filled on row intake, drained on memory writes.
module tb_sys_result_writer;

  localparam int DW = 16;
  localparam int AS = 2;
  localparam int AW = 10;
  localparam int FD = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             write_start = 1'b0;
  logic [AW-1:0]    addr_des = '0;
  logic [3:0]       row_count = '0;
  logic             result_valid = 1'b0;
  logic [AS*DW-1:0] result_in = '0;
  logic             result_ready;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_ready = 1'b1;
  logic             busy;
  logic             write_done;
  logic [1:0]       dbg_state;

  sys_result_writer #(
    .datawith(DW), .array_size(AS), .addr_width(AW), .fifo_depth(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .write_start(write_start), .addr_des(addr_des),
    .row_count(row_count), .result_valid(result_valid), .result_in(result_in),
    .result_ready(result_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy),
    .write_done(write_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int write_cnt = 0;
  int accept_cnt = 0;
  int done_cnt = 0;
  int first_write_cyc = -1;
  int last_write_cyc = 0;
  int done_cyc = 0;
  int done_before;
  int n;
  bit accepted_flag = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] last_data = '0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] relu_neg_exp;

  logic [AW-1:0] sb_base = '0;
  int            sb_rows = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_q[$];

  function automatic logic [DW-1:0] relu_model(input logic [DW-1:0] w);
`ifdef WB_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs at the falling edge: everything seen here transfers on the next rising edge.
  task automatic score();
    cyc++;
    accepted_flag = 1'b0;
    if (result_valid && result_ready) begin
      for (int c = 0; c < AS; c++) begin
        exp_q.push_back(relu_model(result_in[c*DW +: DW]));
        exp_addr_q.push_back(sb_base + AW'(sb_rows * AS + c));
      end
      sb_rows++;
      accept_cnt++;
      accepted_flag = 1'b1;
    end
    if (mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        chk("write_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
        chk("mem_wdata", 32'(mem_wdata), 32'(exp_q.pop_front()));
      end
      write_cnt++;
      prev_addr = last_addr;
      last_addr = mem_addr;
      prev_data = last_data;
      last_data = mem_wdata;
      if (first_write_cyc < 0) first_write_cyc = cyc;
      last_write_cyc = cyc;
    end
    if (write_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    score();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    write_cnt = 0;
    accept_cnt = 0;
    done_cnt = 0;
    first_write_cyc = -1;
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic start(input logic [AW-1:0] base, input logic [3:0] rows);
    sb_base = base;
    sb_rows = 0;
    addr_des = base;
    row_count = rows;
    write_start = 1'b1;
    tick();
    write_start = 1'b0;
  endtask

  task automatic offer_row(input logic [DW-1:0] c0, input logic [DW-1:0] c1);
    int k = 0;
    result_in = {c1, c0};
    result_valid = 1'b1;
    do begin
      tick();
      k++;
    end while (!accepted_flag && k < 50);
    result_valid = 1'b0;
    chk("row_accepted", 32'(accepted_flag), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int start_cnt = done_cnt;
    int k = 0;
    while (done_cnt == start_cnt && k < budget) begin
      tick();
      k++;
    end
    chk("done_within_budget", 32'(done_cnt - start_cnt), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result_ready", 32'(result_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_write_done", 32'(write_done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    tick();

    // Abort mid-run with two rows buffered
    clear_stats();
    mem_ready = 1'b0;
    start(10'h040, 4'd4);
    chk("ready_after_start", 32'(result_ready), 32'd1);
    offer_row(16'h0011, 16'h0022);
    offer_row(16'h0033, 16'h0044);
    chk("abort_we_pending", 32'(mem_we), 32'd1);
    done_before = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_wdata", 32'(mem_wdata), 32'd0);
    chk("abort_ready", 32'(result_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("abort_no_done", 32'(done_cnt), 32'(done_before));
    chk("abort_no_write", 32'(write_cnt), 32'd0);

    // Nominal two-row block
    clear_stats();
    start(10'h010, 4'd2);
    offer_row(16'h0001, 16'h0002);
    offer_row(16'h0003, 16'h0004);
    wait_done(20);
    chk("dflt_writes", 32'(write_cnt), 32'd4);
    chk("dflt_consecutive", 32'(last_write_cyc - first_write_cyc), 32'd3);
    chk("dflt_done_latency", 32'(done_cyc - last_write_cyc), 32'd1);
    chk("dflt_last_addr", 32'(last_addr), 32'h013);
    chk("dflt_last_data", 32'(last_data), 32'h0004);
    chk("dflt_busy_low", 32'(busy), 32'd0);
    chk("dflt_q_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();
    chk("dflt_single_done", 32'(done_cnt), 32'd1);

    // Backpressure on the second word
    clear_stats();
    start(10'h010, 4'd2);
    offer_row(16'h0001, 16'h0002);
    offer_row(16'h0003, 16'h0004);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_we", 32'(mem_we), 32'd1);
      chk("bp_addr", 32'(mem_addr), 32'h011);
      chk("bp_wdata", 32'(mem_wdata), 32'h0002);
      tick();
    end
    mem_ready = 1'b1;
    wait_done(20);
    chk("bp_writes", 32'(write_cnt), 32'd4);

    // FIFO fills while memory stalls
    clear_stats();
    mem_ready = 1'b0;
    start(10'h000, 4'd6);
    result_in = {16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF))};
    result_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (accepted_flag)
        result_in = {16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF))};
    end
    chk("full_accepted", 32'(accept_cnt), 32'd4);
    chk("full_ready_low", 32'(result_ready), 32'd0);
    chk("full_no_writes", 32'(write_cnt), 32'd0);
    mem_ready = 1'b1;
    n = 0;
    while (done_cnt == 0 && n < 80) begin
      tick();
      n++;
      if (accepted_flag)
        result_in = {16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF))};
    end
    repeat (3) tick();
    result_valid = 1'b0;
    chk("full_done", 32'(done_cnt), 32'd1);
    chk("full_total_accepted", 32'(accept_cnt), 32'd6);
    chk("full_writes", 32'(write_cnt), 32'd12);
    chk("full_q_empty", 32'(exp_q.size()), 32'd0);

    // Zero rows
    clear_stats();
    start(10'h055, 4'd0);
    chk("zero_done_high", 32'(write_done), 32'd1);
    chk("zero_no_we", 32'(mem_we), 32'd0);
    tick();
    chk("zero_done_low", 32'(write_done), 32'd0);
    chk("zero_busy_low", 32'(busy), 32'd0);
    chk("zero_done_cnt", 32'(done_cnt), 32'd1);
    chk("zero_writes", 32'(write_cnt), 32'd0);

    // Address wrap
    clear_stats();
    start(10'h3FF, 4'd1);
    offer_row(16'hAAAA, 16'h5555);
    wait_done(20);
    chk("wrap_first_addr", 32'(prev_addr), 32'h3FF);
    chk("wrap_second_addr", 32'(last_addr), 32'h000);
    chk("wrap_writes", 32'(write_cnt), 32'd2);

    // write_start while running is ignored
    clear_stats();
    start(10'h100, 4'd1);
    addr_des = 10'h200;
    row_count = 4'd3;
    write_start = 1'b1;
    tick();
    write_start = 1'b0;
    offer_row(16'h1234, 16'h5678);
    wait_done(20);
    repeat (2) tick();
    chk("ign_writes", 32'(write_cnt), 32'd2);
    chk("ign_first_addr", 32'(prev_addr), 32'h100);
    chk("ign_last_addr", 32'(last_addr), 32'h101);
    chk("ign_idle", 32'(busy), 32'd0);

    // Sign handling on written words
`ifdef WB_RELU_EN
    relu_neg_exp = 16'h0000;
`else
    relu_neg_exp = 16'h8000;
`endif
    clear_stats();
    start(10'h020, 4'd1);
    offer_row(16'h7FFF, 16'h8000);
    wait_done(20);
    chk("relu_pos", 32'(prev_data), 32'h7FFF);
    chk("relu_neg", 32'(last_data), 32'(relu_neg_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sys_result_writer.md
# sys_result_writer

Downstream write-back stage for the systolic array. It captures completed result rows (`array_size` words per row) from the array output and buffers them in a small FIFO. It serialises each row into single-word writes to the output memory, starting at a programmed base address. `write_done` pulses to the controller when the programmed number of rows has been committed.

## Interface
Parameters:
- `datawith`, 16, width of one result word
- `array_size`, 2, words per result row (array columns)
- `addr_width`, 10, output memory address width
- `fifo_depth`, 4, row-buffer depth in rows (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `write_start`  in  1  one-cycle request; latches `addr_des` and `row_count`
- `addr_des`  in  `addr_width`  base address of the result block
- `row_count`  in  4  number of rows to write back; 0 means none
- `result_valid`  in  1  `result_in` holds a valid row
- `result_in`  in  `array_size*datawith`  result row; column c = bits [c*datawith +: datawith]
- `result_ready`  out  1  row is accepted this cycle when `result_valid && result_ready`
- `mem_we`  out  1  write request
- `mem_addr`  out  `addr_width`  write address
- `mem_wdata`  out  `datawith`  write data
- `mem_ready`  in  1  memory accepts the word this cycle when `mem_we && mem_ready`
- `busy`  out  1  high in RUN and DONE
- `write_done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN: `write_start` is high and `row_count`≠0. This cycle latches the base address, `row_count`, and clears the counters.
  - IDLE→DONE: `write_start` is high and `row_count`=0. No memory writes occur.
  - RUN→DONE: the cycle the final word of row `row_count-1` is accepted by memory.
  - DONE→IDLE: unconditionally after one cycle. `write_done`=1 only in DONE.
- `write_start` is ignored in RUN and DONE.
- Intake:
  - `result_ready` = (state==RUN) && FIFO not full && rows_accepted < `row_count`.
  - Rows offered beyond `row_count`, or while not in RUN, are not taken.
- Drain:
  - `mem_we` = (state==RUN) && FIFO not empty.
  - `mem_wdata` = column `col` of the head row, where `col` counts 0…`array_size-1`.
  - `mem_addr` = base + rows_written*`array_size` + `col`, truncated modulo 2^`addr_width`. Wrap-around is silent.
- On each accepted word, `col` increments. On the last column, `col`→0, the head row pops, and rows_written increments.
- `mem_ready`=0 holds `mem_we`, `mem_addr` and `mem_wdata` stable until the word is accepted.
- A push and a pop in the same cycle are both performed, and the occupancy count is unchanged. A push into a full FIFO cannot occur because `result_ready` is low.
- Counter widths: rows_accepted and rows_written are 5 bits. `col` is ⌈log2(`array_size`)⌉ bits, with a minimum of 1.

## Timing
- Reset values: `result_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `write_done`=0. The FSM resets to IDLE, the FIFO to empty, and all counters to 0.
- An asserted `rst_n` mid-operation aborts immediately: buffered rows are discarded and no `write_done` is generated.
- `result_ready` first rises in the cycle after `write_start` is accepted.
- With the FIFO empty and `mem_ready`=1, a row accepted in cycle N produces column 0 on `mem_we` in cycle N+1. Subsequent columns follow on consecutive cycles.
- Throughput: one word per cycle while `mem_ready`=1. The intake sustains one row per `array_size` cycles without stalling once the FIFO is primed.
- `write_done` is high in the cycle after the final word is accepted. `busy` falls in the cycle after that.
- Memory outputs are registered or driven directly from FIFO/counter registers. There is no combinational path from `mem_ready` to `mem_addr` or `mem_wdata`.

## Configuration
- `WB_RELU_EN` defined: each word is treated as signed two's-complement. Negative words (MSB=1) are written as 0, and non-negative words pass unchanged. The clamp is applied at `mem_wdata` and adds no latency.
- `WB_RELU_EN` undefined: words are written unmodified.

## Test plan
- Reset a busy block mid-RUN with 2 rows buffered (`rst_n` low for 1 cycle) → all outputs 0, FSM back to IDLE, no `write_done`. A following `write_start` operates normally.
- Defaults: `addr_des`=0x010, `row_count`=2, rows {0x0002,0x0001} then {0x0004,0x0003}, `mem_ready`=1 → writes (0x010,0x0001), (0x011,0x0002), (0x012,0x0003), (0x013,0x0004) on consecutive cycles. `write_done` is pulsed once, one cycle after the last write.
- Backpressure: same stimulus with `mem_ready` low for 3 cycles during the 2nd word → `mem_we`, `mem_addr`=0x011 and `mem_wdata`=0x0002 held stable. The total write count is still 4.
- FIFO full: `row_count`=6, `result_valid` held high, `mem_ready`=0 → exactly 4 rows accepted, then `result_ready`=0. After releasing `mem_ready`, 12 writes complete and the 7th offered row is never accepted.
- Edge cases:
  - `row_count`=0 → `write_done` pulses in the cycle after `write_start`, with no `mem_we`.
  - `addr_des`=0x3FF, `row_count`=1 → addresses 0x3FF then 0x000 (wrap).
  - `write_start` pulsed during RUN → ignored.
- `WB_RELU_EN` defined: row {0x8000,0x7FFF} → writes 0x7FFF then 0x0000. With the macro undefined, the writes are 0x7FFF then 0x8000.
